// File: rtl/alu_issue_stage.sv
// alu_issue_stage: resolves and registers ALU operands behind a valid/ready
// handshake with flush. It also counts the operations issued to the ALU.
// Ports:
//   id_*        decoded instruction from ID (valid/ready)
//   fwd_ex_*    forwarding source in EX/MEM
//   fwd_wb_*    forwarding source in MEM/WB
//   flush       kills the held op and any op being accepted
//   ex_*, A, B, SELOP  registered bundle to the ALU (valid/ready)
//   issue_count wrap-around count of consumed ops
module alu_issue_stage #(
    parameter int ANCHO = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [AW-1:0]    id_rs1_addr,
    input  logic [AW-1:0]    id_rs2_addr,
    input  logic [AW-1:0]    id_rd_addr,
    input  logic [ANCHO-1:0] id_rs1_data,
    input  logic [ANCHO-1:0] id_rs2_data,
    input  logic [ANCHO-1:0] id_imm,
    input  logic             id_use_imm,
    input  logic [3:0]       id_selop,
    input  logic             id_reg_write,
    input  logic             fwd_ex_we,
    input  logic [AW-1:0]    fwd_ex_rd,
    input  logic [ANCHO-1:0] fwd_ex_data,
    input  logic             fwd_wb_we,
    input  logic [AW-1:0]    fwd_wb_rd,
    input  logic [ANCHO-1:0] fwd_wb_data,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [ANCHO-1:0] A,
    output logic [ANCHO-1:0] B,
    output logic [3:0]       SELOP,
    output logic [AW-1:0]    ex_rd_addr,
    output logic             ex_reg_write,
    output logic             ex_illegal,
    output logic [31:0]      issue_count
);

    logic             valid_q, valid_d;
    logic [ANCHO-1:0] a_q, a_d;
    logic [ANCHO-1:0] b_q, b_d;
    logic [3:0]       selop_q, selop_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic             rw_q, rw_d;
    logic             ill_q, ill_d;
    logic [31:0]      cnt_q, cnt_d;

    logic             accept;
    logic             issue;
    logic             legal;
    logic             is_shift;
    logic [ANCHO-1:0] rs1_val;
    logic [ANCHO-1:0] rs2_val;
    logic [ANCHO-1:0] b_val;

    // x0 is hardwired: never forwarded even if a producer names rd=0.
    function automatic logic [ANCHO-1:0] resolve(
        input logic [AW-1:0]    addr,
        input logic [ANCHO-1:0] rf
    );
        logic [ANCHO-1:0] r;
        r = rf;
        if (addr == '0)
            r = '0;
        else if (fwd_ex_we && fwd_ex_rd == addr)
            r = fwd_ex_data;
        else if (fwd_wb_we && fwd_wb_rd == addr)
            r = fwd_wb_data;
        return r;
    endfunction

    assign id_ready = !valid_q || ex_ready;
    assign accept   = id_valid && id_ready && !flush;
    assign issue    = valid_q && ex_ready && !flush;

    always_comb begin
        legal    = 1'b1;
        is_shift = 1'b0;
        unique case (id_selop)
            4'b0000, 4'b1000, 4'b0111,
            4'b0110, 4'b0100, 4'b0010: legal = 1'b1;
            4'b0001, 4'b0101, 4'b1101: is_shift = 1'b1;
            default:                   legal = 1'b0;
        endcase
    end

    always_comb begin
        rs1_val = resolve(id_rs1_addr, id_rs1_data);
        rs2_val = resolve(id_rs2_addr, id_rs2_data);
        b_val   = id_use_imm ? id_imm : rs2_val;
        // Shifters only look at the shift amount; clear the rest.
        if (is_shift)
            b_val = {{(ANCHO-5){1'b0}}, b_val[4:0]};
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        selop_d = selop_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        ill_d   = ill_q;
        if (accept) begin
            a_d     = rs1_val;
            b_d     = b_val;
            selop_d = legal ? id_selop : 4'b0000;
            rd_d    = id_rd_addr;
            rw_d    = id_reg_write && legal;
            ill_d   = !legal;
        end

        if (flush)
            valid_d = 1'b0;
        else if (accept)
            valid_d = 1'b1;
        else if (ex_ready)
            valid_d = 1'b0;
        else
            valid_d = valid_q;

        cnt_d = cnt_q + {31'b0, issue};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            selop_q <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            selop_q <= selop_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign A            = a_q;
    assign B            = b_q;
    assign SELOP        = selop_q;
    assign ex_rd_addr   = rd_q;
    assign ex_reg_write = rw_q;
    assign ex_illegal   = ill_q;
    assign issue_count  = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for alu_issue_stage.
// Expected ops are queued on acceptance and checked while held/consumed.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm;
    logic [3:0]  id_selop;
    logic        id_reg_write;
    logic        fwd_ex_we;
    logic [4:0]  fwd_ex_rd;
    logic [31:0] fwd_ex_data;
    logic        fwd_wb_we;
    logic [4:0]  fwd_wb_rd;
    logic [31:0] fwd_wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] A, B;
    logic [3:0]  SELOP;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        ex_illegal;
    logic [31:0] issue_count;

    alu_issue_stage #(.ANCHO(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_selop(id_selop), .id_reg_write(id_reg_write),
        .fwd_ex_we(fwd_ex_we), .fwd_ex_rd(fwd_ex_rd),
        .fwd_ex_data(fwd_ex_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd),
        .fwd_wb_data(fwd_wb_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .A(A), .B(B), .SELOP(SELOP),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_illegal(ex_illegal), .issue_count(issue_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic        m_valid;
    logic [31:0] m_cnt;
    int          n_chk;
    int          n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] res(input logic [4:0] addr,
                                        input logic [31:0] rf);
        if (addr == 5'd0) return 32'd0;
        if (fwd_ex_we && fwd_ex_rd == addr) return fwd_ex_data;
        if (fwd_wb_we && fwd_wb_rd == addr) return fwd_wb_data;
        return rf;
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic ok;
        ok = id_selop inside {4'b0000, 4'b1000, 4'b0111, 4'b0110,
                              4'b0100, 4'b0001, 4'b0101, 4'b1101,
                              4'b0010};
        e.a = res(id_rs1_addr, id_rs1_data);
        e.b = id_use_imm ? id_imm : res(id_rs2_addr, id_rs2_data);
        if (id_selop inside {4'b0001, 4'b0101, 4'b1101})
            e.b = e.b & 32'h1F;
        e.sel = ok ? id_selop : 4'b0000;
        e.rd  = id_rd_addr;
        e.rw  = id_reg_write && ok;
        e.ill = !ok;
        return e;
    endfunction

    task automatic rand_inputs();
        id_rs1_addr  = 5'($urandom_range(0, 3));
        id_rs2_addr  = 5'($urandom_range(0, 3));
        id_rd_addr   = 5'($urandom_range(0, 31));
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_imm       = $urandom;
        id_use_imm   = 1'($urandom_range(0, 1));
        id_selop     = 4'($urandom_range(0, 15));
        id_reg_write = 1'($urandom_range(0, 1));
        fwd_ex_we    = 1'($urandom_range(0, 1));
        fwd_ex_rd    = 5'($urandom_range(0, 3));
        fwd_ex_data  = $urandom;
        fwd_wb_we    = 1'($urandom_range(0, 1));
        fwd_wb_rd    = 5'($urandom_range(0, 3));
        fwd_wb_data  = $urandom;
    endtask

    // One cycle, entered and left just after a falling edge.
    task automatic cyc(input logic v, input logic fl, input logic rdy);
        exp_t e;
        logic acc;
        id_valid = v;
        flush    = fl;
        ex_ready = rdy;
        #1;
        chk("id_ready", 32'(id_ready), 32'(!m_valid || rdy));
        if (m_valid) begin
            chk("sb_size", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                e = sb[0];
                chk("A", A, e.a);
                chk("B", B, e.b);
                chk("SELOP", 32'(SELOP), 32'(e.sel));
                chk("rd", 32'(ex_rd_addr), 32'(e.rd));
                chk("reg_write", 32'(ex_reg_write), 32'(e.rw));
                chk("illegal", 32'(ex_illegal), 32'(e.ill));
            end
        end
        acc = v && (!m_valid || rdy) && !fl;
        if (m_valid && (fl || rdy) && sb.size() > 0)
            e = sb.pop_front();
        if (m_valid && rdy && !fl)
            m_cnt = m_cnt + 32'd1;
        if (acc)
            sb.push_back(model());
        if (fl)
            m_valid = 1'b0;
        else if (acc)
            m_valid = 1'b1;
        else if (rdy)
            m_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("issue_count", issue_count, m_cnt);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] base;
        n_chk = 0;
        n_err = 0;
        m_valid = 1'b0;
        m_cnt = 32'd0;
        rst_n = 1'b0;
        id_valid = 1'b1;
        flush = 1'b0;
        ex_ready = 1'b0;
        rand_inputs();

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_A", A, 32'd0);
        chk("rst_B", B, 32'd0);
        chk("rst_SELOP", 32'(SELOP), 32'd0);
        chk("rst_rd", 32'(ex_rd_addr), 32'd0);
        chk("rst_rw", 32'(ex_reg_write), 32'd0);
        chk("rst_ill", 32'(ex_illegal), 32'd0);
        chk("rst_cnt", issue_count, 32'd0);
        chk("rst_ready", 32'(id_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        id_rs1_addr = 5'd5;  id_rs1_data = 32'h33;
        id_rs2_addr = 5'd7;  id_rs2_data = 32'h44;
        id_use_imm = 1'b0;   id_selop = 4'b0000;
        id_reg_write = 1'b1; id_rd_addr = 5'd9;
        fwd_ex_we = 1'b1; fwd_ex_rd = 5'd5; fwd_ex_data = 32'h11;
        fwd_wb_we = 1'b1; fwd_wb_rd = 5'd5; fwd_wb_data = 32'h22;
        cyc(1'b1, 1'b0, 1'b1);
        chk("fwd_ex_pri", A, 32'h11);

        fwd_ex_we = 1'b0;
        cyc(1'b1, 1'b0, 1'b1);
        chk("fwd_wb", A, 32'h22);

        id_rs1_addr = 5'd0;
        fwd_ex_we = 1'b1; fwd_ex_rd = 5'd0;
        fwd_wb_rd = 5'd0;
        cyc(1'b1, 1'b0, 1'b1);
        chk("x0_nofwd", A, 32'd0);

        id_use_imm = 1'b1; id_imm = 32'hFFFF_FFE3;
        id_selop = 4'b0001;
        cyc(1'b1, 1'b0, 1'b1);
        chk("shift_imm", B, 32'h3);
        id_selop = 4'b0000;
        cyc(1'b1, 1'b0, 1'b1);
        chk("add_imm", B, 32'hFFFF_FFE3);

        id_selop = 4'b0011; id_reg_write = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        chk("ill_selop", 32'(SELOP), 32'd0);
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_rw", 32'(ex_reg_write), 32'd0);
        chk("ill_valid", 32'(ex_valid), 32'd1);

        // Stall with changing inputs, then flush the held op.
        rand_inputs();
        id_selop = 4'b0111;
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            cyc(1'b1, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b1);
        chk("flush_valid", 32'(ex_valid), 32'd0);

        // Counter wrap.
        cyc(1'b0, 1'b0, 1'b1);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        rand_inputs();
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("wrap", issue_count, 32'd0);

        base = m_cnt;
        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            cyc(1'b1, 1'b0, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk("burst10", issue_count, base + 32'd10);

        for (int i = 0; i < 60; i++) begin
            rand_inputs();
            cyc(1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)));
        end

        // Reset while holding an op discards it uncounted.
        rand_inputs();
        cyc(1'b1, 1'b0, 1'b0);
        ex_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_cnt = 32'd0;
        sb.delete();
        chk("rst_hold_valid", 32'(ex_valid), 32'd0);
        chk("rst_hold_cnt", issue_count, 32'd0);
        chk("rst_hold_A", A, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rand_inputs();
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
